// File: rtl/montmul_if.sv
// Request/response bundle for the Montgomery multiplier: operands and start in,
// result and status back.
interface montmul_if #(
  parameter int WIDTH = 512
);
  logic             start;
  logic             sq;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_m;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport master (
    output start, sq, in_a, in_b, in_m,
    input  result, busy, done
  );

  modport slave (
    input  start, sq, in_a, in_b, in_m,
    output result, busy, done
  );
endinterface

// File: rtl/montmul_param.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M,
// one multiplier bit per cycle, fixed latency of WIDTH+2 cycles.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// ITER  | one Montgomery step per cycle, WIDTH cycles
// SUB   | conditional final subtraction into the result register
// DONE  | one-cycle completion pulse
module montmul_param #(
  parameter int WIDTH = 512,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic      clk,
  input logic      resetn,
  montmul_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH+1:0] c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic [WIDTH+1:0] sum_ab;
  logic [WIDTH+1:0] sum_m;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // C stays below 2M, so C + B + M < 4M fits in WIDTH+2 bits.
  always_comb begin
    sum_ab = c_q + (a_q[0] ? {2'b00, b_q} : '0);
    sum_m  = sum_ab[0] ? (sum_ab + {2'b00, m_q}) : sum_ab;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    res_d   = res_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.in_a;
          b_d     = bus.sq ? bus.in_a : bus.in_b;
          m_d     = bus.in_m;
          c_d     = '0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        c_d   = sum_m >> 1;
        a_d   = a_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = SUB;
        end
      end
      SUB: begin
        // When C >= M the difference is below M, so the low WIDTH bits are exact.
        if (c_q >= {2'b00, m_q}) begin
          res_d = c_q[WIDTH-1:0] - m_q;
        end else begin
          res_d = c_q[WIDTH-1:0];
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.result = res_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);

endmodule
